cis_frame_scheduler: RTL and testbench

- Frame-level sequencer driving the integration input of the CIS pixel controller.
- Generates programmable exposure windows, repeats them over N frames with an inter-frame gap, and in global-shutter mode issues per-pixel integration pulses gated by the SPROCKET end-of-conversion (EOC) handshake.
- Sits between the configuration register bank and the CIS pixel controller; it is the only source of that controller's integration and global_shutter inputs.

---
 rtl/cis_frame_scheduler.sv | 251 +++++++++++++++++++++++++
 tb/tb_cis_frame_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cis_frame_scheduler.sv
// cis_frame_scheduler
//   Frame-level sequencer for the CIS pixel controller. Produces exposure
//   windows repeated over a programmable number of frames with an
//   inter-frame gap. In global-shutter mode, after the exposure it issues one
//   short integration pulse per remaining pixel, each gated by the SPROCKET
//   end-of-conversion (eoc) pulse.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   start, abort        one-cycle control pulses
//   clk_div             pixel-controller divider; sets the minimum level hold
//   gs_mode             global-shutter request (latched at start)
//   exposure_cycles     integration-high time per frame
//   gap_cycles          integration-low time between frames
//   num_frames          frames per run, 0 = free-run until abort
//   timeout_cycles      max wait for eoc, 0 = disabled
//   eoc                 end-of-conversion, one pulse per pixel
//   integration         pixel controller integration input (registered)
//   global_shutter      latched gs_mode
//   busy                run in progress
//   frame_done          one-cycle pulse per completed frame
//   frame_count         frames completed in this run
//   timeout_err         sticky eoc-timeout flag, cleared by next start
//   aborted             one-cycle pulse when an abort is taken
module cis_frame_scheduler #(
    parameter int PIXEL_CLUSTER_SIZE = 16,
    parameter int EXP_W              = 24,
    parameter int GAP_W              = 16,
    parameter int FRAME_W            = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [9:0]         clk_div,
    input  logic               gs_mode,
    input  logic [EXP_W-1:0]   exposure_cycles,
    input  logic [GAP_W-1:0]   gap_cycles,
    input  logic [FRAME_W-1:0] num_frames,
    input  logic [GAP_W-1:0]   timeout_cycles,
    input  logic               eoc,
    output logic               integration,
    output logic               global_shutter,
    output logic               busy,
    output logic               frame_done,
    output logic [FRAME_W-1:0] frame_count,
    output logic               timeout_err,
    output logic               aborted
);

    // One shared phase counter wide enough for exposure, gap and hold_min.
    localparam int CW0   = (EXP_W > GAP_W) ? EXP_W : GAP_W;
    localparam int CNT_W = (CW0 > 12) ? CW0 : 12;
    localparam int PIX_W = $clog2(PIXEL_CLUSTER_SIZE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXPOSE,
        S_WAIT_EOC,
        S_GS_PULSE,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic               integration_q, integration_d;
    logic               global_shutter_q, global_shutter_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic [FRAME_W-1:0] frame_count_q, frame_count_d;
    logic               timeout_err_q, timeout_err_d;
    logic               aborted_q, aborted_d;
    logic [CNT_W-1:0]   exp_eff_q, exp_eff_d;
    logic [CNT_W-1:0]   gap_eff_q, gap_eff_d;
    logic [11:0]        hold_min_q, hold_min_d;
    logic [FRAME_W-1:0] num_frames_q, num_frames_d;
    logic [GAP_W-1:0]   timeout_q, timeout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;

    // Minimum hold guarantees every level spans at least one divider enable.
    logic [11:0]      hold_min_in;
    logic [CNT_W-1:0] exp_in, gap_in, hold_in;
    logic [CNT_W-1:0] cnt_inc;
    logic [GAP_W-1:0] tmo_inc;
    logic [PIX_W-1:0] pix_inc, n_pix;

    assign hold_min_in = (12'(clk_div) + 12'd1) << 1;
    assign hold_in     = CNT_W'(hold_min_in);
    assign exp_in      = CNT_W'(exposure_cycles);
    assign gap_in      = CNT_W'(gap_cycles);
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign tmo_inc     = tmo_cnt_q + GAP_W'(1);
    assign pix_inc     = pix_cnt_q + PIX_W'(1);
    assign n_pix       = global_shutter_q ? PIX_W'(PIXEL_CLUSTER_SIZE) : PIX_W'(1);

    always_comb begin
        state_d          = state_q;
        integration_d    = integration_q;
        global_shutter_d = global_shutter_q;
        busy_d           = busy_q;
        frame_done_d     = 1'b0;
        frame_count_d    = frame_count_q;
        timeout_err_d    = timeout_err_q;
        aborted_d        = 1'b0;
        exp_eff_d        = exp_eff_q;
        gap_eff_d        = gap_eff_q;
        hold_min_d       = hold_min_q;
        num_frames_d     = num_frames_q;
        timeout_d        = timeout_q;
        cnt_d            = cnt_q;
        tmo_cnt_d        = tmo_cnt_q;
        pix_cnt_d        = pix_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    global_shutter_d = gs_mode;
                    exp_eff_d        = (exp_in > hold_in) ? exp_in : hold_in;
                    gap_eff_d        = (gap_in > hold_in) ? gap_in : hold_in;
                    hold_min_d       = hold_min_in;
                    num_frames_d     = num_frames;
                    timeout_d        = timeout_cycles;
                    frame_count_d    = '0;
                    timeout_err_d    = 1'b0;
                    busy_d           = 1'b1;
                    integration_d    = 1'b1;
                    cnt_d            = '0;
                    state_d          = S_EXPOSE;
                end
            end
            S_EXPOSE: begin
                if (cnt_inc == exp_eff_q) begin
                    integration_d = 1'b0;
                    pix_cnt_d     = '0;
                    tmo_cnt_d     = '0;
                    state_d       = S_WAIT_EOC;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WAIT_EOC: begin
                if (eoc) begin
                    cnt_d = '0;
                    if (pix_inc < n_pix) begin
                        pix_cnt_d     = pix_inc;
                        integration_d = 1'b1;
                        state_d       = S_GS_PULSE;
                    end else begin
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + FRAME_W'(1);
                        state_d       = S_GAP;
                    end
                end else if (timeout_q != '0 && tmo_inc == timeout_q) begin
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_inc;
                end
            end
            S_GS_PULSE: begin
                if (cnt_inc == CNT_W'(hold_min_q)) begin
                    integration_d = 1'b0;
                    tmo_cnt_d     = '0;
                    state_d       = S_WAIT_EOC;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_GAP: begin
                if (cnt_inc == gap_eff_q) begin
                    cnt_d = '0;
                    // frame_count already counts the frame that just finished
                    if (num_frames_q == '0 || frame_count_q != num_frames_q) begin
                        integration_d = 1'b1;
                        state_d       = S_EXPOSE;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                integration_d = 1'b0;
                busy_d        = 1'b0;
                state_d       = S_IDLE;
            end
        endcase

        // Abort overrides start/eoc/timeout outcomes decided above.
        if (abort && state_q != S_IDLE) begin
            state_d       = S_IDLE;
            integration_d = 1'b0;
            busy_d        = 1'b0;
            aborted_d     = 1'b1;
            frame_done_d  = 1'b0;
            frame_count_d = frame_count_q;
            timeout_err_d = timeout_err_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            integration_q    <= 1'b0;
            global_shutter_q <= 1'b0;
            busy_q           <= 1'b0;
            frame_done_q     <= 1'b0;
            frame_count_q    <= '0;
            timeout_err_q    <= 1'b0;
            aborted_q        <= 1'b0;
            exp_eff_q        <= '0;
            gap_eff_q        <= '0;
            hold_min_q       <= '0;
            num_frames_q     <= '0;
            timeout_q        <= '0;
            cnt_q            <= '0;
            tmo_cnt_q        <= '0;
            pix_cnt_q        <= '0;
        end else begin
            state_q          <= state_d;
            integration_q    <= integration_d;
            global_shutter_q <= global_shutter_d;
            busy_q           <= busy_d;
            frame_done_q     <= frame_done_d;
            frame_count_q    <= frame_count_d;
            timeout_err_q    <= timeout_err_d;
            aborted_q        <= aborted_d;
            exp_eff_q        <= exp_eff_d;
            gap_eff_q        <= gap_eff_d;
            hold_min_q       <= hold_min_d;
            num_frames_q     <= num_frames_d;
            timeout_q        <= timeout_d;
            cnt_q            <= cnt_d;
            tmo_cnt_q        <= tmo_cnt_d;
            pix_cnt_q        <= pix_cnt_d;
        end
    end

    assign integration    = integration_q;
    assign global_shutter = global_shutter_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign frame_count    = frame_count_q;
    assign timeout_err    = timeout_err_q;
    assign aborted        = aborted_q;

endmodule

// File: tb/tb_cis_frame_scheduler.sv
// Directed bench for cis_frame_scheduler. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_cis_frame_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort, gs_mode, eoc;
    logic [9:0]  clk_div;
    logic [23:0] exposure_cycles;
    logic [15:0] gap_cycles, num_frames, timeout_cycles;
    logic        integration, global_shutter, busy, frame_done, timeout_err, aborted;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;
    int n;
    int good;
    logic seen;

    cis_frame_scheduler #(
        .PIXEL_CLUSTER_SIZE(16), .EXP_W(24), .GAP_W(16), .FRAME_W(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .clk_div(clk_div), .gs_mode(gs_mode), .exposure_cycles(exposure_cycles),
        .gap_cycles(gap_cycles), .num_frames(num_frames),
        .timeout_cycles(timeout_cycles), .eoc(eoc),
        .integration(integration), .global_shutter(global_shutter), .busy(busy),
        .frame_done(frame_done), .frame_count(frame_count),
        .timeout_err(timeout_err), .aborted(aborted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int k = 1);
        repeat (k) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_eoc();
        eoc = 1'b1; tick(); eoc = 1'b0;
    endtask

    // Cycles integration stays high, counted from the current sample.
    task automatic measure_high(output int cnt);
        cnt = 0;
        while (integration === 1'b1 && cnt < 5000) begin cnt++; tick(); end
    endtask

    // Cycles integration stays low while the run is still busy.
    task automatic measure_low(output int cnt);
        cnt = 0;
        while (integration === 1'b0 && busy === 1'b1 && cnt < 5000) begin cnt++; tick(); end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < 5000) begin k++; tick(); end
        chk(tag, busy, 0);
    endtask

    initial begin
        reset = 1'b1; start = 0; abort = 0; gs_mode = 0; eoc = 0;
        clk_div = 0; exposure_cycles = 0; gap_cycles = 0; num_frames = 0; timeout_cycles = 0;
        tick(2);
        reset = 1'b0;
        tick();
        chk("reset_outputs", {integration, global_shutter, busy, frame_done, timeout_err, aborted}, 0);
        chk("reset_frame_count", frame_count, 0);

        // Rolling single frame
        clk_div = 0; exposure_cycles = 10; gap_cycles = 4; num_frames = 1; gs_mode = 0;
        pulse_start();
        chk("roll_rise_after_start", integration, 1);
        chk("roll_busy", busy, 1);
        measure_high(n);
        chk("roll_exposure_len", n, 10);
        tick(19);
        chk("roll_no_early_done", frame_done, 0);
        pulse_eoc();
        chk("roll_frame_done", frame_done, 1);
        chk("roll_frame_count", frame_count, 1);
        tick();
        chk("roll_done_one_cycle", frame_done, 0);
        tick(2);
        chk("roll_busy_in_gap", busy, 1);
        tick();
        chk("roll_busy_fall", busy, 0);
        chk("roll_count_hold", frame_count, 1);

        // Global shutter: hold_min = 4, 15 gated pulses, done on 16th eoc
        clk_div = 1; gs_mode = 1; exposure_cycles = 50; gap_cycles = 0; num_frames = 1;
        pulse_start();
        chk("gs_latched", global_shutter, 1);
        measure_high(n);
        chk("gs_exposure_len", n, 50);
        good = 0; seen = 0;
        for (int p = 0; p < 15; p++) begin
            tick(7);
            pulse_eoc();
            seen = seen | frame_done;
            measure_high(n);
            if (n == 4) good++;
        end
        chk("gs_pulse_count_len4", good, 15);
        chk("gs_no_early_done", seen, 0);
        tick(7);
        pulse_eoc();
        chk("gs_frame_done", frame_done, 1);
        chk("gs_frame_count", frame_count, 1);
        wait_idle("gs_idle");

        // Multi-frame with a mid-run start and mid-run config change
        clk_div = 0; gs_mode = 0; exposure_cycles = 6; gap_cycles = 5; num_frames = 3;
        pulse_start();
        chk("mf_gs_relatched", global_shutter, 0);
        for (int f = 1; f <= 3; f++) begin
            if (f == 2) begin
                start = 1'b1; exposure_cycles = 20; tick(); start = 1'b0;
                measure_high(n);
                n = n + 1;
            end else begin
                measure_high(n);
            end
            chk($sformatf("mf_exposure_len_f%0d", f), n, 6);
            tick(2);
            pulse_eoc();
            chk($sformatf("mf_frame_count_f%0d", f), frame_count, f);
            measure_low(n);
            chk($sformatf("mf_gap_len_f%0d", f), n, 5);
        end
        chk("mf_busy_end", busy, 0);
        chk("mf_final_count", frame_count, 3);

        // Clamping: hold_min = 8 overrides zero exposure/gap
        clk_div = 3; exposure_cycles = 0; gap_cycles = 0; num_frames = 2;
        pulse_start();
        measure_high(n);
        chk("clamp_exposure", n, 8);
        tick(2);
        pulse_eoc();
        measure_low(n);
        chk("clamp_gap", n, 8);
        measure_high(n);
        chk("clamp_exposure_f2", n, 8);
        tick(2);
        pulse_eoc();
        wait_idle("clamp_idle");
        chk("clamp_count", frame_count, 2);

        // Timeout
        clk_div = 0; exposure_cycles = 10; gap_cycles = 4; num_frames = 1; timeout_cycles = 100;
        pulse_start();
        measure_high(n);
        seen = 0;
        for (int i = 0; i < 99; i++) begin tick(); seen = seen | frame_done; end
        chk("tmo_not_yet", timeout_err, 0);
        chk("tmo_busy_before", busy, 1);
        tick();
        chk("tmo_err_set", timeout_err, 1);
        chk("tmo_busy_low", busy, 0);
        chk("tmo_no_frame_done", seen | frame_done, 0);
        tick(3);
        chk("tmo_sticky", timeout_err, 1);

        // Next start clears timeout_err; then abort with coincident eoc/start
        timeout_cycles = 0; num_frames = 2;
        pulse_start();
        chk("tmo_cleared_by_start", timeout_err, 0);
        measure_high(n);
        tick(2);
        pulse_eoc();
        chk("ab_count_before", frame_count, 1);
        measure_low(n);
        chk("ab_in_expose", integration, 1);
        abort = 1'b1; eoc = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; eoc = 1'b0; start = 1'b0;
        chk("ab_integration_low", integration, 0);
        chk("ab_aborted_pulse", aborted, 1);
        chk("ab_busy_low", busy, 0);
        chk("ab_count_held", frame_count, 1);
        tick();
        chk("ab_aborted_one_cycle", aborted, 0);
        chk("ab_stays_idle", busy, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("ab_idle_no_effect", aborted, 0);

        // Async reset during GS_PULSE
        clk_div = 1; gs_mode = 1; exposure_cycles = 4; num_frames = 1;
        pulse_start();
        measure_high(n);
        tick(2);
        pulse_eoc();
        tick();
        chk("rst_in_gs_pulse", {integration, busy, global_shutter}, 3'b111);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_outputs", {integration, global_shutter, busy, frame_done, timeout_err, aborted}, 0);
        chk("rst_async_count", frame_count, 0);
        tick();
        reset = 1'b0;
        tick(2);
        chk("rst_stays_idle", {integration, busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
